// File: rtl/stream_demux_pkg.sv
// Shared types and defaults for the stream_demux_n 1-to-N demultiplexer.
package stream_demux_pkg;

    localparam int unsigned DEF_N_CH   = 8;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_CNT_W  = 8;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    function automatic int unsigned sel_w(input int unsigned n);
        return 32'($clog2(n));
    endfunction

endpackage

// File: rtl/stream_demux_slice.sv
// Generic single-entry valid/ready register slice; accepts a new beat
// in the same cycle the held one drains, so full throughput is kept.
module stream_demux_slice #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_vld;
    logic [W-1:0] r_data;

    assign o_ready = !r_vld || i_ready;
    assign o_valid = r_vld;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_data <= '0;
        end else if (i_valid && o_ready) begin
            r_vld  <= 1'b1;
            r_data <= i_data;
        end else if (i_ready) begin
            r_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux_n.sv
// Registered 1-to-N valid/ready stream demultiplexer with saturating drop counter.
// Optional packet route lock enabled by defining STREAM_DEMUX_ROUTE_LOCK_EN.
module stream_demux_n
    import stream_demux_pkg::*;
#(
    parameter int unsigned N_CH   = DEF_N_CH,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [sel_w(N_CH)-1:0]   in_sel,
    input  logic                     in_last,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [N_CH-1:0]          out_last,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int unsigned SEL_W = sel_w(N_CH);
    localparam int unsigned PAY_W = SEL_W + DATA_W + 1;

    logic [SEL_W-1:0]  w_eff_sel;
    logic              w_in_range;
    logic              w_accept;
    logic              w_vld_q;
    logic [PAY_W-1:0]  w_pay_q;
    logic [SEL_W-1:0]  w_ch_q;
    logic [DATA_W-1:0] w_data_q;
    logic              w_last_q;
    logic [CNT_W-1:0]  r_drop_cnt;

    assign w_in_range = ({1'b0, w_eff_sel} < (SEL_W+1)'(N_CH));
    assign w_accept   = in_valid && in_ready;
    assign w_ch_q     = w_pay_q[PAY_W-1 -: SEL_W];
    assign w_data_q   = w_pay_q[DATA_W:1];
    assign w_last_q   = w_pay_q[0];
    assign drop_cnt   = r_drop_cnt;

    // Out-of-range beats are handshaken but never reach the slice.
    stream_demux_slice #(
        .W (PAY_W)
    ) u_slice (
        .clk     (clk),
        .rst     (rst),
        .i_valid (in_valid && w_in_range),
        .o_ready (in_ready),
        .i_data  ({w_eff_sel, in_data, in_last}),
        .o_valid (w_vld_q),
        .i_ready (out_ready[w_ch_q]),
        .o_data  (w_pay_q)
    );

    // Channel decode with zero-gating of every unselected lane.
    always_comb begin
        out_valid = '0;
        out_last  = '0;
        out_data  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_vld_q && (w_ch_q == SEL_W'(i))) begin
                out_valid[i]                  = 1'b1;
                out_last[i]                   = w_last_q;
                out_data[i*DATA_W +: DATA_W]  = w_data_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_accept && !w_in_range && (r_drop_cnt != {CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

`ifdef STREAM_DEMUX_ROUTE_LOCK_EN
    lock_state_e      r_lock_state;
    lock_state_e      w_lock_state_nxt;
    logic [SEL_W-1:0] r_lock_sel;
    logic [SEL_W-1:0] w_lock_sel_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_state <= UNLOCKED;
            r_lock_sel   <= '0;
        end else begin
            r_lock_state <= w_lock_state_nxt;
            r_lock_sel   <= w_lock_sel_nxt;
        end
    end

    // Dropped packets lock too, so every beat of them is counted.
    always_comb begin
        w_lock_state_nxt = r_lock_state;
        w_lock_sel_nxt   = r_lock_sel;
        w_eff_sel        = in_sel;
        case (r_lock_state)
            UNLOCKED: begin
                if (w_accept && !in_last) begin
                    w_lock_state_nxt = LOCKED;
                    w_lock_sel_nxt   = in_sel;
                end
            end
            LOCKED: begin
                w_eff_sel = r_lock_sel;
                if (w_accept && in_last) begin
                    w_lock_state_nxt = UNLOCKED;
                end
            end
            default: w_lock_state_nxt = UNLOCKED;
        endcase
    end
`else
    assign w_eff_sel = in_sel;
`endif

endmodule

// File: tb/tb_stream_demux_n.sv
// Bench for stream_demux_n: directed scenarios plus random traffic on an
// 8-channel and a 6-channel/2-bit-counter instance against a beat-level model.
module tb_stream_demux_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic [2:0]  in_sel;
    logic [7:0]  in_data;
    logic        in_last;

    logic        in_ready8;
    logic [7:0]  out_valid8, out_ready8, out_last8, drop8;
    logic [63:0] out_data8;

    logic        in_ready6;
    logic [5:0]  out_valid6, out_ready6, out_last6;
    logic [47:0] out_data6;
    logic [1:0]  drop6;

    stream_demux_n #(.N_CH(8), .DATA_W(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .out_last(out_last8), .drop_cnt(drop8)
    );

    stream_demux_n #(.N_CH(6), .DATA_W(8), .CNT_W(2)) dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6),
        .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6),
        .out_last(out_last6), .drop_cnt(drop6)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Beat-level model: at most one held beat per instance, a drop tally and the packet route.
    bit         m_hv[2];
    int         m_ch[2];
    logic [7:0] m_data[2];
    bit         m_last[2];
    int         m_drop[2];
    bit         m_lock[2];
    int         m_lsel[2];

    function automatic int n_of(input int d);
        return (d == 0) ? 8 : 6;
    endfunction

    function automatic int cmax_of(input int d);
        return (d == 0) ? 255 : 3;
    endfunction

    function automatic logic [7:0] ordy(input int d);
        return (d == 0) ? out_ready8 : {2'b00, out_ready6};
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_hv[d] = 0; m_ch[d] = 0; m_data[d] = '0; m_last[d] = 0;
            m_drop[d] = 0; m_lock[d] = 0; m_lsel[d] = 0;
        end
    end

    always @(posedge clk) begin
        logic [7:0] r;
        bit         acc;
        int         es;
        for (int d = 0; d < 2; d++) begin
            r = ordy(d);
            if (rst) begin
                m_hv[d] = 0; m_drop[d] = 0; m_lock[d] = 0;
            end else begin
                acc = in_valid && (!m_hv[d] || r[m_ch[d]]);
                if (m_hv[d] && r[m_ch[d]]) m_hv[d] = 0;
                if (acc) begin
                    es = m_lock[d] ? m_lsel[d] : int'(in_sel);
`ifdef STREAM_DEMUX_ROUTE_LOCK_EN
                    if (in_last) m_lock[d] = 0;
                    else if (!m_lock[d]) begin
                        m_lock[d] = 1;
                        m_lsel[d] = int'(in_sel);
                    end
`endif
                    if (es < n_of(d)) begin
                        m_hv[d] = 1; m_ch[d] = es; m_data[d] = in_data; m_last[d] = in_last;
                    end else if (m_drop[d] < cmax_of(d)) begin
                        m_drop[d]++;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [7:0]  ev, el, r;
        logic [63:0] ed;
        bit          er;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                ev = '0; el = '0; ed = '0;
                r  = ordy(d);
                if (m_hv[d]) begin
                    ev[m_ch[d]]         = 1'b1;
                    el[m_ch[d]]         = m_last[d];
                    ed[m_ch[d]*8 +: 8]  = m_data[d];
                end
                er = !m_hv[d] || r[m_ch[d]];
                if (d == 0) begin
                    chk("valid8", 64'(out_valid8), 64'(ev));
                    chk("data8", out_data8, ed);
                    chk("last8", 64'(out_last8), 64'(el));
                    chk("ready8", 64'(in_ready8), 64'(er));
                    chk("drop8", 64'(drop8), 64'(m_drop[d]));
                end else begin
                    chk("valid6", 64'(out_valid6), 64'(ev));
                    chk("data6", 64'(out_data6), ed);
                    chk("last6", 64'(out_last6), 64'(el));
                    chk("ready6", 64'(in_ready6), 64'(er));
                    chk("drop6", 64'(drop6), 64'(m_drop[d]));
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int sel, input int data, input bit last);
        in_valid = 1'b1;
        in_sel   = 3'(sel);
        in_data  = 8'(data);
        in_last  = last;
    endtask

    initial begin
        logic [63:0] exp_d;
        int          exp_ch[4];
        bit          hold;

        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; in_last = 1'b0;
        out_ready8 = '1; out_ready6 = '1;
        tick;
        chk_en = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        chk("rst_valid", 64'(out_valid8), 64'h0);
        chk("rst_data", out_data8, 64'h0);
        chk("rst_drop", 64'(drop8), 64'h0);
        chk("rst_ready", 64'(in_ready8), 64'h1);

        // Each channel in turn at full rate.
        for (int s = 0; s < 8; s++) begin
            beat(s, 'hA0 + s, 1'b1);
            tick;
            exp_d = 64'(8'('hA0 + s)) << (8 * s);
            chk("t1_valid", 64'(out_valid8), 64'(1) << s);
            chk("t1_data", out_data8, exp_d);
        end
        in_valid = 1'b0;
        tick;
        chk("t1_idle", 64'(out_valid8), 64'h0);

        // Stalled destination holds the beat and backpressures the input.
        beat(3, 'h55, 1'b1);
        out_ready8[3] = 1'b0; out_ready6[3] = 1'b0;
        tick;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t2_valid", 64'(out_valid8), 64'h08);
            chk("t2_data", out_data8, 64'h55 << 24);
            chk("t2_ready", 64'(in_ready8), 64'h0);
            if (k < 3) tick;
        end
        out_ready8[3] = 1'b1; out_ready6[3] = 1'b1;
        #1;
        chk("t2_release_ready", 64'(in_ready8), 64'h1);
        tick;
        chk("t2_drained", 64'(out_valid8), 64'h0);

        // Back-to-back beats to different channels.
        beat(2, 'h11, 1'b1);
        tick;
        chk("t3_first", 64'(out_valid8), 64'h04);
        chk("t3_first_data", out_data8, 64'h11 << 16);
        beat(5, 'h22, 1'b1);
        tick;
        chk("t3_second", 64'(out_valid8), 64'h20);
        chk("t3_second_data", out_data8, 64'h22 << 40);
        in_valid = 1'b0;
        tick;

        // Reset while a beat is held discards it.
        beat(4, 'h99, 1'b1);
        out_ready8[4] = 1'b0; out_ready6[4] = 1'b0;
        tick;
        chk("t5_held", 64'(out_valid8), 64'h10);
        rst = 1'b1; in_valid = 1'b0;
        tick;
        chk("t5_valid", 64'(out_valid8), 64'h0);
        chk("t5_data", out_data8, 64'h0);
        chk("t5_drop", 64'(drop8), 64'h0);
        rst = 1'b0; out_ready8 = '1; out_ready6 = '1;
        tick;
        chk("t5_gone", 64'(out_valid8), 64'h0);
        chk("t5_ready", 64'(in_ready8), 64'h1);

        // Out-of-range selects on the 6-channel instance, then saturation.
        beat(6, 'h01, 1'b1); tick;
        beat(7, 'h02, 1'b1); tick;
        beat(6, 'h03, 1'b1); tick;
        chk("t4_drop3", 64'(drop6), 64'h3);
        chk("t4_novalid", 64'(out_valid6), 64'h0);
        beat(7, 'h04, 1'b1); tick;
        beat(6, 'h05, 1'b1); tick;
        chk("t4_sat", 64'(drop6), 64'h3);
        chk("t4_drop8", 64'(drop8), 64'h0);
        in_valid = 1'b0;
        tick;

        // Multi-beat packet routing.
`ifdef STREAM_DEMUX_ROUTE_LOCK_EN
        exp_ch[0] = 1; exp_ch[1] = 1; exp_ch[2] = 1; exp_ch[3] = 6;
`else
        exp_ch[0] = 1; exp_ch[1] = 6; exp_ch[2] = 3; exp_ch[3] = 6;
`endif
        beat(1, 'hB1, 1'b0); tick;
        chk("t6_b0", 64'(out_valid8), 64'(1) << exp_ch[0]);
        beat(6, 'hB2, 1'b0); tick;
        chk("t6_b1", 64'(out_valid8), 64'(1) << exp_ch[1]);
        beat(3, 'hB3, 1'b1); tick;
        chk("t6_b2", 64'(out_valid8), 64'(1) << exp_ch[2]);
        chk("t6_b2_last", 64'(out_last8), 64'(1) << exp_ch[2]);
        beat(6, 'hB4, 1'b1); tick;
        chk("t6_b3", 64'(out_valid8), 64'(1) << exp_ch[3]);
        chk("t6_b3_data", out_data8, 64'hB4 << (8 * exp_ch[3]));
        in_valid = 1'b0;
        tick;

        // Random traffic with random backpressure and occasional reset.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            hold = in_valid && !(in_ready8 && in_ready6);
            @(posedge clk);
            #1;
            rst        = ($urandom_range(0, 299) == 0);
            out_ready8 = 8'($urandom | $urandom);
            out_ready6 = 6'($urandom | $urandom);
            if (!hold || rst) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 3'($urandom);
                in_data  = 8'($urandom);
                in_last  = ($urandom_range(0, 2) == 0);
            end
        end
        rst = 1'b0; in_valid = 1'b0;
        tick;
        tick;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
